// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard/stall unit: FSM state encoding, register-file
// constants and the packed control-output bundle with its named settings.
package hazard_stall_unit_pkg;

  localparam int unsigned RegAw = 4;
  // Register 0 is hard-wired to zero, so it never carries a real dependence.
  localparam logic [RegAw-1:0] ZeroReg = '0;

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StDrain,
    StHalted
  } hsu_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic id_ex_write;
    logic ex_mem_write;
    logic mem_wb_bubble;
    logic halted;
  } hsu_ctl_t;

  localparam hsu_ctl_t CtlRun = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                  id_ex_bubble: 1'b0, id_ex_write: 1'b1, ex_mem_write: 1'b1,
                                  mem_wb_bubble: 1'b0, halted: 1'b0};
  // D-cache miss: everything up to EX/MEM holds, MEM/WB receives a NOP.
  localparam hsu_ctl_t CtlFreeze = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                     id_ex_bubble: 1'b0, id_ex_write: 1'b0, ex_mem_write: 1'b0,
                                     mem_wb_bubble: 1'b1, halted: 1'b0};
  // Unforwardable dependence: hold PC and IF/ID, inject a NOP into EX.
  localparam hsu_ctl_t CtlStall = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                    id_ex_bubble: 1'b1, id_ex_write: 1'b1, ex_mem_write: 1'b1,
                                    mem_wb_bubble: 1'b0, halted: 1'b0};
  // Front end idle (I-cache miss or HLT drain): NOPs enter ID, downstream proceeds.
  localparam hsu_ctl_t CtlFrontIdle = '{pc_write: 1'b0, if_id_write: 1'b1, if_id_flush: 1'b1,
                                        id_ex_bubble: 1'b0, id_ex_write: 1'b1, ex_mem_write: 1'b1,
                                        mem_wb_bubble: 1'b0, halted: 1'b0};
  localparam hsu_ctl_t CtlBrFlush = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                      id_ex_bubble: 1'b0, id_ex_write: 1'b1, ex_mem_write: 1'b1,
                                      mem_wb_bubble: 1'b0, halted: 1'b0};
  localparam hsu_ctl_t CtlHalted = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                     id_ex_bubble: 1'b0, id_ex_write: 1'b0, ex_mem_write: 1'b0,
                                     mem_wb_bubble: 1'b0, halted: 1'b1};

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline <-> hazard/stall unit bundle.
//   master: pipeline side, drives the stage status fields and observes the controls.
//   slave : hazard unit side, observes the stage status and drives the controls.
interface hazard_stall_unit_if #(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned CNT_W  = 16
);
  // Stage status
  logic [REG_AW-1:0] IF_ID_Rs;
  logic [REG_AW-1:0] IF_ID_Rt;
  logic              IF_ID_UsesRs;
  logic              IF_ID_UsesRt;
  logic              IF_ID_IsBranch;
  logic              IF_ID_IsBranchReg;
  logic              IF_ID_IsHalt;
  logic              BranchTaken;
  logic              ID_EX_MemRead;
  logic              ID_EX_RegWrite;
  logic              ID_EX_SetsFlags;
  logic [REG_AW-1:0] ID_EX_Rd;
  logic              EX_MEM_MemRead;
  logic [REG_AW-1:0] EX_MEM_Rd;
  logic              IF_Miss;
  logic              MEM_Miss;
  // Controls and status
  logic              PC_Write;
  logic              IF_ID_Write;
  logic              IF_ID_Flush;
  logic              ID_EX_Bubble;
  logic              ID_EX_Write;
  logic              EX_MEM_Write;
  logic              MEM_WB_Bubble;
  logic              Halted;
  logic [CNT_W-1:0]  StallCount;
  logic [CNT_W-1:0]  FlushCount;

  modport master (
    output IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRs, IF_ID_UsesRt, IF_ID_IsBranch, IF_ID_IsBranchReg,
           IF_ID_IsHalt, BranchTaken, ID_EX_MemRead, ID_EX_RegWrite, ID_EX_SetsFlags,
           ID_EX_Rd, EX_MEM_MemRead, EX_MEM_Rd, IF_Miss, MEM_Miss,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Write, EX_MEM_Write,
           MEM_WB_Bubble, Halted, StallCount, FlushCount
  );

  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRs, IF_ID_UsesRt, IF_ID_IsBranch, IF_ID_IsBranchReg,
           IF_ID_IsHalt, BranchTaken, ID_EX_MemRead, ID_EX_RegWrite, ID_EX_SetsFlags,
           ID_EX_Rd, EX_MEM_MemRead, EX_MEM_Rd, IF_Miss, MEM_Miss,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Write, EX_MEM_Write,
           MEM_WB_Bubble, Halted, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter: counts cycles with inc=1, sticks at all-ones.
//   clk   : clock
//   rst_n : synchronous active-low reset, clears the count
//   inc   : increment request for this cycle
//   count : current value
module hazard_stall_unit_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard/stall unit for the 5-stage pipeline. Catches the hazards the forwarding
// path cannot resolve (load-use, branch flag/register dependences, cache misses),
// drives the per-stage stall/flush/bubble controls, sequences the HLT drain and
// keeps saturating stall/flush counters.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : stage status in, stage controls / Halted / counters out
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned REG_AW       = RegAw,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_stall_unit_if.slave  bus
);

  localparam logic [REG_AW-1:0] Zero = REG_AW'(ZeroReg);
  localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN_CYCLES - 1);

  hsu_state_e        state_q, state_d;
  logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;

  logic     lu, bf, br, dep_stall, halt_go;
  hsu_ctl_t ctl;
  logic     flush_evt, stall_inc;

  // Hazard terms
  assign lu = bus.ID_EX_MemRead && (bus.ID_EX_Rd != Zero) &&
              ((bus.IF_ID_UsesRs && (bus.IF_ID_Rs == bus.ID_EX_Rd)) ||
               (bus.IF_ID_UsesRt && (bus.IF_ID_Rt == bus.ID_EX_Rd)));
  assign bf = bus.IF_ID_IsBranch && bus.ID_EX_SetsFlags;
  assign br = bus.IF_ID_IsBranchReg && (bus.IF_ID_Rs != Zero) &&
              ((bus.ID_EX_RegWrite && (bus.ID_EX_Rd == bus.IF_ID_Rs)) ||
               (bus.EX_MEM_MemRead && (bus.EX_MEM_Rd == bus.IF_ID_Rs)));
  assign dep_stall = lu || bf || br;

  // HLT only leaves ID in a cycle where nothing is holding it back.
  assign halt_go = bus.IF_ID_IsHalt && !bus.MEM_Miss && !dep_stall && !bus.IF_Miss;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StRun;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      // MEM_WAIT with the miss gone behaves exactly like RUN, so leaving it costs no cycle.
      StRun, StMemWait: begin
        if (bus.MEM_Miss) begin
          state_d = StMemWait;
        end else if (halt_go) begin
          state_d     = StDrain;
          drain_cnt_d = DrainLoad;
        end else begin
          state_d = StRun;
        end
      end
      StDrain: begin
        if (!bus.MEM_Miss) begin
          if (drain_cnt_q == '0) begin
            state_d = StHalted;
          end else begin
            drain_cnt_d = drain_cnt_q - DrainW'(1);
          end
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase
  end

  // Outputs
  always_comb begin
    ctl       = CtlRun;
    flush_evt = 1'b0;
    case (state_q)
      StRun, StMemWait: begin
        if (bus.MEM_Miss) begin
          ctl = CtlFreeze;
        end else if (dep_stall) begin
          ctl = CtlStall;
        end else if (bus.IF_Miss) begin
          ctl = CtlFrontIdle;
        end else if (bus.BranchTaken) begin
          ctl       = CtlBrFlush;
          flush_evt = 1'b1;
        end
      end
      StDrain:  ctl = bus.MEM_Miss ? CtlFreeze : CtlFrontIdle;
      StHalted: ctl = CtlHalted;
      default:  ctl = CtlRun;
    endcase
  end

  assign bus.PC_Write      = ctl.pc_write;
  assign bus.IF_ID_Write   = ctl.if_id_write;
  assign bus.IF_ID_Flush   = ctl.if_id_flush;
  assign bus.ID_EX_Bubble  = ctl.id_ex_bubble;
  assign bus.ID_EX_Write   = ctl.id_ex_write;
  assign bus.EX_MEM_Write  = ctl.ex_mem_write;
  assign bus.MEM_WB_Bubble = ctl.mem_wb_bubble;
  assign bus.Halted        = ctl.halted;

  // A halted core is not "stalling", so it stops accumulating stall cycles.
  assign stall_inc = !ctl.pc_write && (state_q != StHalted);

  hazard_stall_unit_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (bus.StallCount)
  );

  hazard_stall_unit_sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_evt),
    .count (bus.FlushCount)
  );

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer-side companion to the operand forwarding path in the 5-stage pipeline.
- Detects hazards that forwarding cannot resolve: load-use, flag/register dependences of ID-stage branches, and I-/D-cache misses.
- Drives the stall, flush and bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Sequences HLT drain and keeps saturating stall/flush counters.

Parameters:
- REG_AW, 4, register address width (register 0 hard-wired zero)
- CNT_W, 16, width of performance counters
- DRAIN_CYCLES, 4, cycles after HLT leaves ID until the pipeline is empty

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- IF_ID_Rs  in  REG_AW  source 1 of instruction in ID
- IF_ID_Rt  in  REG_AW  source 2 of instruction in ID
- IF_ID_UsesRs  in  1  ID instruction reads Rs
- IF_ID_UsesRt  in  1  ID instruction reads Rt
- IF_ID_IsBranch  in  1  conditional branch (B) in ID
- IF_ID_IsBranchReg  in  1  register branch (BR) in ID; target register is Rs
- IF_ID_IsHalt  in  1  HLT in ID
- BranchTaken  in  1  ID-stage branch resolved taken
- ID_EX_MemRead  in  1  load in EX
- ID_EX_RegWrite  in  1  EX instruction writes a register
- ID_EX_SetsFlags  in  1  EX instruction updates flags
- ID_EX_Rd  in  REG_AW  destination of EX instruction
- EX_MEM_MemRead  in  1  load in MEM
- EX_MEM_Rd  in  REG_AW  destination of MEM instruction
- IF_Miss  in  1  I-cache busy, fetched word not valid
- MEM_Miss  in  1  D-cache busy, MEM access not complete
- PC_Write  out  1  PC may update
- IF_ID_Write  out  1  IF/ID may load
- IF_ID_Flush  out  1  IF/ID loads a NOP
- ID_EX_Bubble  out  1  ID/EX loads a NOP
- ID_EX_Write  out  1  ID/EX may load
- EX_MEM_Write  out  1  EX/MEM may load
- MEM_WB_Bubble  out  1  MEM/WB loads a NOP
- Halted  out  1  pipeline drained after HLT
- StallCount  out  CNT_W  cycles with PC_Write=0
- FlushCount  out  CNT_W  taken-branch flushes

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=RUN, drain counter=0, both counters=0, Halted=0.
  - Control outputs take their RUN, no-hazard values: all *_Write=1, flush/bubble=0.
- Control outputs are combinational from the inputs and the registered state, so each takes effect in the same cycle.
- Hazard terms (in RUN):
  - LU (load-use): ID_EX_MemRead & ID_EX_Rd!=0 & (match Rs with UsesRs, or match Rt with UsesRt).
  - BF (branch-flag): IF_ID_IsBranch & ID_EX_SetsFlags.
  - BR: IF_ID_IsBranchReg & Rs!=0 & one of:
    - ID_EX_RegWrite & ID_EX_Rd==Rs
    - EX_MEM_MemRead & EX_MEM_Rd==Rs
- Priority: MEM_Miss > (LU|BF|BR) > IF_Miss > BranchTaken.
  - MEM_Miss: PC_Write=IF_ID_Write=ID_EX_Write=EX_MEM_Write=0, MEM_WB_Bubble=1. Whole front end frozen.
  - LU|BF|BR: PC_Write=IF_ID_Write=0, ID_EX_Bubble=1. BranchTaken is ignored this cycle.
  - IF_Miss: PC_Write=0, IF_ID_Flush=1, downstream proceeds.
  - BranchTaken alone: IF_ID_Flush=1, PC_Write=1.
- FSM states RUN, MEM_WAIT, DRAIN, HALTED:
  - RUN -> MEM_WAIT when MEM_Miss=1. MEM_WAIT holds the MEM_Miss controls until MEM_Miss=0, then returns to RUN; exit takes no extra cycle.
  - RUN -> DRAIN when IF_ID_IsHalt=1 and no stall condition is present. The HLT itself advances; the counter loads DRAIN_CYCLES-1.
  - DRAIN:
    - PC_Write=0, IF_ID_Flush=1, downstream proceeds.
    - Counter decrements each cycle; it does not decrement while MEM_Miss=1, and MEM_Miss applies its freeze.
    - At 0 -> HALTED.
  - HALTED: Halted=1, PC_Write=IF_ID_Write=ID_EX_Write=EX_MEM_Write=0; left only by reset.
- Counters:
  - StallCount increments in every cycle with PC_Write=0, except in HALTED.
  - FlushCount increments in every cycle BranchTaken causes a flush.
  - Both saturate at all-ones; no wrap.
- A reset asserted mid-stall or mid-drain overrides everything at that edge.

Decomposition:
- Shared cpu_pkg holds the state encoding and the REG_AW and zero-register constants, used also by the forwarding and decode logic.
- One sub-module, sat_counter (CNT_W, inc, clk, rst_n), instantiated twice.

Test Plan:
- Load-use: ID_EX_MemRead=1, Rd=5, IF_ID_Rs=5, UsesRs=1 -> exactly 1 cycle of PC_Write=0 and ID_EX_Bubble=1; StallCount=1.
- Rd=0 load with Rs=0 -> no stall. LU together with BranchTaken -> stall only, FlushCount unchanged.
- MEM_Miss high 3 cycles while LU is also present -> 3 cycles with EX_MEM_Write=0 and MEM_WB_Bubble=1, then 1 LU cycle; StallCount=4.
- BranchTaken with no hazard -> IF_ID_Flush=1 for 1 cycle. Repeat 0xFFFF+2 times -> FlushCount holds 0xFFFF.
- HLT in ID -> DRAIN 4 cycles with PC_Write=0, then Halted=1 and stays high; a MEM_Miss during DRAIN extends DRAIN by its duration.
- rst_n=0 during MEM_WAIT -> next cycle state RUN, counters 0, all *_Write=1.
